// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl
// Runs a tortoise/hare (Floyd) attractor search over one GNR node array.
// Nodes are loaded with an initial state, then stepped: the hare (s1) moves
// one step per start_s1 pulse, and the tortoise (s0) moves on every second
// start_s0 pulse. When the two meet at an even hare step count, the meeting
// state is captured. The hare is then stepped alone until it returns to that
// state, which gives the attractor period.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for an initial state; init_ready high
// LOAD   | one-cycle reset_nos strobe, counters cleared
// RUN    | tortoise and hare stepping together until they meet
// PERIOD | hare stepping alone until it returns to the meeting state
// DONE   | result presented on res_*, waiting for res_ready

module gnr_attractor_ctrl #(
    parameter int NODES     = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_valid,
    output logic             init_ready,
    input  logic [NODES-1:0] init_data,
    output logic [NODES-1:0] init_state,
    output logic             reset_nos,
    output logic             start_s0,
    output logic             start_s1,
    input  logic [NODES-1:0] s0_vec,
    input  logic [NODES-1:0] s1_vec,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [NODES-1:0] res_state,
    output logic [CNT_W-1:0] res_steps,
    output logic [CNT_W-1:0] res_period,
    output logic             res_timeout
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        PERIOD = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] period_cnt;

    logic hit;
    logic phit;
    logic run_to;
    logic per_to;

    // Meeting / return detection; hit is only meaningful at even hare step counts,
    // where the tortoise has taken exactly half as many steps.
    always_comb begin
        hit    = (state == RUN) && !step_cnt[0] && (step_cnt != '0) && (s0_vec == s1_vec);
        phit   = (state == PERIOD) && (period_cnt != '0) && (s1_vec == res_state);
        run_to = (state == RUN) && !hit && (step_cnt == MAX_C);
        per_to = (state == PERIOD) && !phit && (period_cnt == MAX_C);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (init_valid) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (hit) state_nxt = PERIOD;
                     else if (run_to) state_nxt = DONE;
            PERIOD:  if (phit || per_to) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and handshakes; steps stop in the detection or timeout cycle itself.
    always_comb begin
        init_ready = (state == IDLE);
        reset_nos  = (state == LOAD);
        res_valid  = (state == DONE);
        start_s0   = (state == RUN) && !hit && !run_to;
        start_s1   = ((state == RUN) && !hit && !run_to) ||
                     ((state == PERIOD) && !phit && !per_to);
    end

    // Counters, captured init state and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_state  <= '0;
            step_cnt    <= '0;
            period_cnt  <= '0;
            res_state   <= '0;
            res_steps   <= '0;
            res_period  <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_valid) init_state <= init_data;
                end
                LOAD: begin
                    step_cnt    <= '0;
                    period_cnt  <= '0;
                    res_state   <= '0;
                    res_steps   <= '0;
                    res_period  <= '0;
                    res_timeout <= 1'b0;
                end
                RUN: begin
                    if (hit) begin
                        res_state <= s0_vec;
                        res_steps <= step_cnt;
                    end else if (step_cnt == MAX_C) begin
                        res_timeout <= 1'b1;
                        res_steps   <= MAX_C;
                    end else begin
                        step_cnt <= step_cnt + CNT_W'(1);
                    end
                end
                PERIOD: begin
                    if (phit) begin
                        res_period <= period_cnt;
                    end else if (period_cnt == MAX_C) begin
                        res_timeout <= 1'b1;
                        res_period  <= '0;
                    end else begin
                        period_cnt <= period_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: a byte-wide node array model driven by the
// controller strobes, a table of hand-derived searches, a mid-search reset,
// and random maps checked against an iterate-the-map reference search.

module tb_gnr_attractor_ctrl;

    localparam int NODES = 8;
    localparam int CNT_W = 16;
    localparam int MAXS  = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             init_valid = 1'b0;
    logic             init_ready;
    logic [NODES-1:0] init_data = '0;
    logic [NODES-1:0] init_state;
    logic             reset_nos;
    logic             start_s0;
    logic             start_s1;
    logic [NODES-1:0] s0_vec = '0;
    logic [NODES-1:0] s1_vec = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [NODES-1:0] res_state;
    logic [CNT_W-1:0] res_steps;
    logic [CNT_W-1:0] res_period;
    logic             res_timeout;

    always #5 clk = ~clk;

    gnr_attractor_ctrl #(.NODES(NODES), .CNT_W(CNT_W), .MAX_STEPS(MAXS)) dut (
        .clk(clk), .rst(rst),
        .init_valid(init_valid), .init_ready(init_ready), .init_data(init_data),
        .init_state(init_state), .reset_nos(reset_nos),
        .start_s0(start_s0), .start_s1(start_s1),
        .s0_vec(s0_vec), .s1_vec(s1_vec),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_state(res_state), .res_steps(res_steps),
        .res_period(res_period), .res_timeout(res_timeout)
    );

    // Node array model: the next-state map f_map is applied to the whole vector.
    logic [7:0] f_map [256];
    logic       tort_phase = 1'b0;

    always @(posedge clk) begin
        if (reset_nos) begin
            s0_vec     <= init_state;
            s1_vec     <= init_state;
            tort_phase <= 1'b0;
        end else begin
            if (start_s0) begin
                if (!tort_phase) s0_vec <= f_map[s0_vec];
                tort_phase <= !tort_phase;
            end
            if (start_s1) s1_vec <= f_map[s1_vec];
        end
    end

    typedef struct {
        int         kind;
        logic [7:0] init;
        logic [15:0] steps;
        logic [15:0] period;
        logic [7:0] state;
        logic       timeout;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic fill_map(input int kind, input int range_hi);
        for (int i = 0; i < 256; i++) begin
            case (kind)
                1:       f_map[i] = 8'(i);
                2:       f_map[i] = (i < 8) ? 8'((i + 1) % 8) : 8'(i);
                3:       f_map[i] = 8'($urandom_range(0, range_hi));
                default: f_map[i] = 8'(i);
            endcase
        end
        if (kind == 1) begin
            f_map[8'h10] = 8'h21;
            f_map[8'h21] = 8'h32;
            f_map[8'h32] = 8'h43;
            f_map[8'h43] = 8'h21;
        end
    endtask

    function automatic logic [7:0] iter(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = f_map[y];
        return y;
    endfunction

    // Floyd search as a plain loop over hare step counts.
    function automatic vec_t ref_search(input logic [7:0] init);
        vec_t r;
        r.kind = 3; r.init = init; r.steps = 0; r.period = 0; r.state = 0; r.timeout = 1'b0;
        for (int k = 0; k <= MAXS; k++) begin
            if (k > 0 && k % 2 == 0 && iter(init, k / 2) == iter(init, k)) begin
                r.steps = 16'(k);
                r.state = iter(init, k / 2);
                for (int p = 1; p <= MAXS; p++) begin
                    if (iter(r.state, p) == r.state) begin
                        r.period = 16'(p);
                        return r;
                    end
                end
                r.timeout = 1'b1;
                return r;
            end
        end
        r.steps = 16'(MAXS);
        r.timeout = 1'b1;
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input bit hold, input bit inject);
        int  nrst;
        bit  seen;
        int  cyc;
        nrst = 0;
        seen = 0;
        cyc  = 0;
        while (!init_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        init_valid = 1'b1;
        init_data  = v.init;
        @(negedge clk);
        init_valid = 1'b0;
        chk("init_state_load", init_state, v.init);
        for (int c = 0; c < 200; c++) begin
            if (reset_nos) nrst++;
            if (res_valid) begin
                seen = 1;
                break;
            end
            if (inject && (c == 4 || c == 9)) begin
                init_valid = 1'b1;
                init_data  = ~v.init;
            end else begin
                init_valid = 1'b0;
            end
            @(negedge clk);
        end
        init_valid = 1'b0;
        chk("result_seen", 32'(seen), 1);
        chk("reset_nos_once", nrst, 1);
        if (inject) chk("init_state_kept", init_state, v.init);
        chk("res_steps", res_steps, v.steps);
        chk("res_period", res_period, v.period);
        chk("res_timeout", res_timeout, v.timeout);
        if (!v.timeout) chk("res_state", res_state, v.state);
        if (hold) begin
            for (int h = 0; h < 5; h++) begin
                @(negedge clk);
                chk("done_ctrl", {res_valid, init_ready, reset_nos, start_s0, start_s1}, 5'b10000);
                chk("done_hold", {res_state, res_steps, res_period, 7'd0, res_timeout},
                    {v.state, v.steps, v.period, 7'd0, v.timeout});
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("ack_to_idle", {res_valid, init_ready}, 2'b01);
    endtask

    vec_t tbl [4];

    initial begin
        vec_t rv;
        int   rng;

        tbl[0] = '{kind: 0, init: 8'h5A, steps: 2, period: 1, state: 8'h5A, timeout: 1'b0};
        tbl[1] = '{kind: 1, init: 8'h10, steps: 6, period: 3, state: 8'h43, timeout: 1'b0};
        tbl[2] = '{kind: 2, init: 8'h00, steps: 10, period: 0, state: 8'h00, timeout: 1'b1};
        tbl[3] = '{kind: 0, init: 8'hC3, steps: 2, period: 1, state: 8'hC3, timeout: 1'b0};

        fill_map(0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", {init_ready, reset_nos, start_s0, start_s1, res_valid}, 5'b10000);
        chk("rst_res", {res_state, res_steps, res_period, 7'd0, res_timeout}, '0);
        chk("rst_init_state", init_state, 0);

        for (int i = 0; i < 4; i++) begin
            fill_map(tbl[i].kind, 0);
            run_vec(tbl[i], i == 0, i == 1);
            if (tbl[i].kind == 2) begin
                chk("timeout_hare_pos", s1_vec, 8'h02);
                chk("timeout_tort_pos", s0_vec, 8'h05);
            end
        end

        // Reset in the middle of RUN, at hare step 3.
        fill_map(2, 0);
        init_valid = 1'b1;
        init_data  = 8'h07;
        @(negedge clk);
        init_valid = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("run_step3_active", {start_s0, start_s1}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ctrl", {init_ready, reset_nos, start_s0, start_s1, res_valid}, 5'b10000);
        chk("abort_res", {res_state, res_steps, res_period, 7'd0, res_timeout}, '0);
        chk("abort_init_state", init_state, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_result", {res_valid, init_ready}, 2'b01);
        fill_map(0, 0);
        run_vec(tbl[0], 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            rng = $urandom_range(3, 12);
            fill_map(3, rng);
            rv = ref_search(8'($urandom_range(0, 255)));
            run_vec(rv, 1'b0, r == 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
